// File: rtl/mod_m_updown_counter.sv
// mod_m_updown_counter
// Programmable modulo-M up/down counter with clear, parallel load and a
// shadowed modulus. A new modulus waits in a pending register and only becomes
// the active terminal value on a wrap step or a clear, so the count is never
// cut short mid-period. The wrap pulse is registered, which keeps it glitch-free
// when it drives the enable of the next stage in a cascaded chain.
module mod_m_updown_counter #(
    parameter int M_MAX     = 16,
    parameter int M_DEFAULT = 10,
    parameter int W         = $clog2(M_MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         mod_wr,
    input  logic [W-1:0] mod_val,
    output logic [W-1:0] q,
    output logic [W-1:0] term,
    output logic         max_tick,
    output logic         min_tick,
    output logic         wrap,
    output logic         mod_pend
);

    // Terminal value after reset, and the largest terminal value the modulus
    // range allows.
    localparam logic [W-1:0] TERM_DEFAULT = W'(M_DEFAULT - 1);
    localparam logic [W-1:0] TERM_LIMIT   = W'(M_MAX - 1);

    // State
    logic [W-1:0] q_q,        q_d;
    logic [W-1:0] term_q,     term_d;
    logic [W-1:0] pend_q,     pend_d;
    logic         mod_pend_q, mod_pend_d;
    logic         wrap_q,     wrap_d;

    // Decoded helpers
    logic [W-1:0] mod_val_sat;
    logic [W-1:0] load_sat;
    logic [W-1:0] next_term;
    logic         at_max;
    logic         at_min;
    logic         wrap_step;

    // When M_MAX fills the count width every encodable mod_val is legal, so
    // no clamp logic is needed; otherwise out-of-range values saturate.
    generate
        if ((1 << W) == M_MAX) begin : g_mod_full_range
            assign mod_val_sat = mod_val;
        end else begin : g_mod_clamped
            assign mod_val_sat = (mod_val > TERM_LIMIT) ? TERM_LIMIT : mod_val;
        end
    endgenerate

    assign at_max = (q_q == term_q);
    assign at_min = (q_q == '0);

    // A load never lands above the active terminal value.
    assign load_sat = (load_val > term_q) ? term_q : load_val;

    // The terminal value to adopt at a boundary. A write in the same cycle
    // overrides whatever was pending. Outside a pending write, pend_q always
    // mirrors term_q, so adopting it is harmless.
    assign next_term = mod_wr ? mod_val_sat : pend_q;

    // Counting direction decides which end of the range is the wrap point.
    assign wrap_step = en && (up ? at_max : at_min);

    // Next-state logic, priority clr > load > en.
    always_comb begin
        q_d        = q_q;
        term_d     = term_q;
        pend_d     = pend_q;
        mod_pend_d = mod_pend_q;
        wrap_d     = 1'b0;

        if (clr) begin
            // A clear is a period boundary: the modulus commits here too.
            q_d        = '0;
            term_d     = next_term;
            pend_d     = next_term;
            mod_pend_d = 1'b0;
        end else begin
            // A modulus write is shadowed unless a wrap step below commits it.
            if (mod_wr) begin
                pend_d     = mod_val_sat;
                mod_pend_d = 1'b1;
            end

            if (load) begin
                q_d = load_sat;
            end else if (en) begin
                if (wrap_step) begin
                    term_d     = next_term;
                    pend_d     = next_term;
                    mod_pend_d = 1'b0;
                    wrap_d     = 1'b1;
                    // A down wrap restarts from the top of the new range.
                    q_d        = up ? '0 : next_term;
                end else if (up) begin
                    q_d = q_q + W'(1);
                end else begin
                    q_d = q_q - W'(1);
                end
            end
        end
    end

    // State registers; reset takes effect immediately, dropping any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q        <= '0;
            term_q     <= TERM_DEFAULT;
            pend_q     <= TERM_DEFAULT;
            mod_pend_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            q_q        <= q_d;
            term_q     <= term_d;
            pend_q     <= pend_d;
            mod_pend_q <= mod_pend_d;
            wrap_q     <= wrap_d;
        end
    end

    assign q        = q_q;
    assign term     = term_q;
    assign max_tick = at_max;
    assign min_tick = at_min;
    assign wrap     = wrap_q;
    assign mod_pend = mod_pend_q;

endmodule

// File: tb/tb_mod_m_updown_counter.sv
// tb_mod_m_updown_counter
// Directed scenarios followed by a randomized run, all compared cycle by cycle
// against a modular-arithmetic reference model of the counter.
module tb_mod_m_updown_counter;

    localparam int M_MAX     = 16;
    localparam int M_DEFAULT = 10;
    localparam int W         = $clog2(M_MAX);

    logic         clk = 1'b0;
    logic         reset;
    logic         en, up, clr, load, mod_wr;
    logic [W-1:0] load_val, mod_val;
    logic [W-1:0] q, term;
    logic         max_tick, min_tick, wrap, mod_pend;

    int checks = 0;
    int errors = 0;

    // Reference model state: count, active terminal, pending terminal,
    // pending flag, wrap pulse.
    int mq, mterm, mpv;
    bit mpend, mwrap;

    mod_m_updown_counter #(
        .M_MAX     (M_MAX),
        .M_DEFAULT (M_DEFAULT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .mod_wr   (mod_wr),
        .mod_val  (mod_val),
        .q        (q),
        .term     (term),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .wrap     (wrap),
        .mod_pend (mod_pend)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq    = 0;
        mterm = M_DEFAULT - 1;
        mpv   = M_DEFAULT - 1;
        mpend = 0;
        mwrap = 0;
    endtask

    // One clock of the counter, expressed as arithmetic modulo (term+1).
    task automatic model_step(input bit e, input bit u, input bit c, input bit l,
                              input int lv, input bit mw, input int mv);
        int mvc;
        int m;
        int newterm;
        bit wrapped;
        mvc     = (mv > M_MAX - 1) ? M_MAX - 1 : mv;
        wrapped = 0;
        if (c) begin
            mq = 0;
            if (mw) begin
                mterm = mvc;
                mpv   = mvc;
            end else if (mpend) begin
                mterm = mpv;
            end
            mpend = 0;
        end else begin
            if (l) begin
                mq = (lv < mterm) ? lv : mterm;
            end else if (e) begin
                m = mterm + 1;
                if (u) begin
                    wrapped = (mq == mterm);
                    mq = (mq + 1) % m;
                end else begin
                    wrapped = (mq == 0);
                    mq = (mq + m - 1) % m;
                end
            end
            if (wrapped) begin
                newterm = mw ? mvc : mpv;
                mterm   = newterm;
                mpv     = newterm;
                mpend   = 0;
                mq      = u ? 0 : newterm;
            end else if (mw) begin
                mpv   = mvc;
                mpend = 1;
            end
        end
        mwrap = wrapped;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        $display("%s: q=%0d term=%0d wrap=%0d pend=%0d max=%0d min=%0d",
                 tag, q, term, wrap, mod_pend, max_tick, min_tick);
        check({tag, ".q"},        32'(q),        32'(mq));
        check({tag, ".term"},     32'(term),     32'(mterm));
        check({tag, ".wrap"},     32'(wrap),     32'(mwrap));
        check({tag, ".mod_pend"}, 32'(mod_pend), 32'(mpend));
        check({tag, ".max_tick"}, 32'(max_tick), 32'(mq == mterm));
        check({tag, ".min_tick"}, 32'(min_tick), 32'(mq == 0));
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic step(input string tag, input bit e, input bit u, input bit c, input bit l,
                        input int lv, input bit mw, input int mv);
        en       = e;
        up       = u;
        clr      = c;
        load     = l;
        load_val = W'(lv);
        mod_wr   = mw;
        mod_val  = W'(mv);
        model_step(e, u, c, l, lv, mw, mv);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        up       = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        mod_wr   = 1'b0;
        mod_val  = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // T1: free-running up count through two wraps.
        for (int i = 0; i < 22; i++) step("T1", 1, 1, 0, 0, 0, 0, 0);

        // T2: down count from 0, wrapping to the top.
        step("T2_clr", 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step("T2", 1, 0, 0, 0, 0, 0, 0);

        // T4: load saturates at term; clr beats load and en, no wrap pulse.
        step("T4_load", 0, 1, 0, 1, 15, 0, 0);
        step("T4_hold", 0, 1, 0, 0, 0, 0, 0);
        step("T4_prio", 1, 1, 1, 1, 7, 0, 0);

        // T3: shadowed modulus write at q=3 commits only at the wrap.
        for (int i = 0; i < 3; i++) step("T3_pre", 1, 1, 0, 0, 0, 0, 0);
        step("T3_wr", 1, 1, 0, 0, 0, 1, 4);
        for (int i = 0; i < 6; i++) step("T3_run", 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("T3_new", 1, 1, 0, 0, 0, 0, 0);

        // Write coinciding with a down wrap is applied directly.
        step("wr_wrap_clr", 0, 1, 1, 0, 0, 0, 0);
        step("wr_wrap", 1, 0, 0, 0, 0, 1, 6);
        step("wr_wrap_run", 1, 0, 0, 0, 0, 0, 0);
        // Last of repeated writes wins; load leaves the pending flag alone.
        step("wr_rep1", 0, 1, 0, 0, 0, 1, 2);
        step("wr_rep2", 0, 1, 0, 1, 13, 1, 11);
        step("wr_rep3", 0, 1, 1, 0, 0, 0, 0);

        // T6: asynchronous reset mid-count with a pending write.
        step("T6_clr", 0, 1, 1, 0, 0, 1, 9);
        for (int i = 0; i < 3; i++) step("T6_pre", 1, 1, 0, 0, 0, 0, 0);
        step("T6_wr", 1, 1, 0, 0, 0, 1, 7);
        for (int i = 0; i < 2; i++) step("T6_run", 1, 1, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("T6_async");
        @(posedge clk);
        #1;
        check_all("T6_held");
        reset = 1'b0;

        // T5: modulus 1 via clr+mod_wr; every enabled cycle wraps.
        step("T5_set", 0, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("T5_up", 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("T5_dn", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("T5_idle", 0, 1, 0, 0, 0, 0, 0);

        // Randomized run.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) != 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 14) == 0,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
